acq_window_sequencer: RTL and testbench

Timed acquisition-window controller for the time-tagger core. It takes byte commands from one cmd_parser channel (mask_bit/data/data_ack). It then drives the photon timer's start_det/stop_det/reset_counter strobes and the pulse-sequencer operate level, so that detectors and lasers run for an exact, host-programmed number of clk cycles. It watches the sample FIFO full flag and records overflow, with optional abort on overflow.

---
 rtl/acq_window_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_acq_window_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_window_sequencer.sv
// Acquisition-window controller: parses host byte commands and sequences the
// photon-timer strobes and pulse-sequencer enable for an exact window length.
module acq_window_sequencer #(
  parameter int LEN_WIDTH      = 32,
  parameter bit OVERFLOW_ABORT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mask_bit,
  input  logic [7:0] data,
  output logic       data_ack,
  input  logic       fifo_full,
  output logic       start_det,
  output logic       stop_det,
  output logic       reset_counter,
  output logic       seq_operate,
  output logic       active,
  output logic       done,
  output logic       overflow
);

  localparam int LEN_BYTES = LEN_WIDTH / 8;
  localparam int BI_W      = (LEN_BYTES > 1) ? $clog2(LEN_BYTES) : 1;
  localparam int POS_W     = $clog2(LEN_WIDTH);
  localparam logic [BI_W-1:0] LAST_IDX = BI_W'(LEN_BYTES - 1);

  localparam logic [7:0] OP_LOAD_LEN = 8'h01;
  localparam logic [7:0] OP_START    = 8'h02;
  localparam logic [7:0] OP_ABORT    = 8'h03;
  localparam logic [7:0] OP_CLR_OVF  = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_ARM, S_RUN, S_STOP, S_DONE
  } state_t;

  typedef enum logic {
    P_OPCODE, P_LEN
  } parse_t;

  state_t               state;
  parse_t               pstate;
  logic                 ack_prev;
  logic                 take;
  logic [BI_W-1:0]      byte_idx;
  logic [POS_W-1:0]     pos;
  logic [LEN_WIDTH-1:0] shadow;
  logic [LEN_WIDTH-1:0] assembled;
  logic [LEN_WIDTH-1:0] length;
  logic [LEN_WIDTH-1:0] count;
  logic                 in_opcode;
  logic                 load_byte;
  logic                 cmd_start;
  logic                 cmd_abort;
  logic                 cmd_clr;
  logic                 ovf_hit;
  logic                 run_exit;

  // Ack is never given two cycles running so the producer can retire mask_bit.
  assign take     = mask_bit & ~ack_prev & ~reset;
  assign data_ack = take;

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_prev <= 1'b0;
    end else begin
      ack_prev <= take;
    end
  end

  assign in_opcode = (pstate == P_OPCODE);
  assign load_byte = take & (pstate == P_LEN);
  assign cmd_start = take & in_opcode & (data == OP_START);
  assign cmd_abort = take & in_opcode & (data == OP_ABORT);
  assign cmd_clr   = take & in_opcode & (data == OP_CLR_OVF);

  assign pos = POS_W'({byte_idx, 3'b000});

  always_comb begin
    assembled            = shadow;
    assembled[pos +: 8]  = data;
  end

  // Length bytes arrive LSB first; the visible length changes only on the last one.
  always_ff @(posedge clk) begin
    if (reset) begin
      pstate   <= P_OPCODE;
      byte_idx <= '0;
      length   <= '0;
    end else if (take) begin
      if (pstate == P_OPCODE) begin
        if (data == OP_LOAD_LEN) begin
          pstate   <= P_LEN;
          byte_idx <= '0;
        end
      end else if (byte_idx == LAST_IDX) begin
        pstate   <= P_OPCODE;
        byte_idx <= '0;
        length   <= assembled;
      end else begin
        byte_idx <= byte_idx + BI_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_byte) begin
      shadow <= assembled;
    end
  end

  assign ovf_hit  = seq_operate & fifo_full;
  assign run_exit = (count == LEN_WIDTH'(1)) | cmd_abort | (OVERFLOW_ABORT & fifo_full);

  // Window length is latched at START so a later LOAD_LEN only affects the next window.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && cmd_start) begin
      count <= length;
    end else if (state == S_RUN) begin
      count <= count - LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      reset_counter <= 1'b0;
      start_det     <= 1'b0;
      stop_det      <= 1'b0;
      seq_operate   <= 1'b0;
      active        <= 1'b0;
      done          <= 1'b0;
    end else begin
      reset_counter <= 1'b0;
      start_det     <= 1'b0;
      stop_det      <= 1'b0;
      done          <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_start && length != '0) begin
            state         <= S_PREP;
            reset_counter <= 1'b1;
            active        <= 1'b1;
          end
        end
        S_PREP: begin
          if (cmd_abort) begin
            state    <= S_STOP;
            stop_det <= 1'b1;
          end else begin
            state     <= S_ARM;
            start_det <= 1'b1;
          end
        end
        S_ARM: begin
          if (cmd_abort) begin
            state    <= S_STOP;
            stop_det <= 1'b1;
          end else begin
            state       <= S_RUN;
            seq_operate <= 1'b1;
          end
        end
        S_RUN: begin
          if (run_exit) begin
            state       <= S_STOP;
            stop_det    <= 1'b1;
            seq_operate <= 1'b0;
          end
        end
        S_STOP: begin
          state  <= S_DONE;
          done   <= 1'b1;
          active <= 1'b0;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state       <= S_IDLE;
          seq_operate <= 1'b0;
          active      <= 1'b0;
        end
      endcase
    end
  end

  // A new overflow in the same cycle as CLR_OVF wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (ovf_hit) begin
      overflow <= 1'b1;
    end else if (cmd_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acq_window_sequencer.sv
// Bench for acq_window_sequencer: two instances (abort-on-overflow and flag-only)
// compared every cycle against a window-schedule model, plus directed totals.
`timescale 1ns/1ps
module tb_acq_window_sequencer;

  localparam int LW = 32;

  logic       clk = 1'b0;
  logic       reset, mask_bit, fifo_full;
  logic [7:0] data;
  logic [1:0] ack, rc, sd, sp, so, act, dn, ovf_o;

  int     tests = 0;
  int     fails = 0;
  longint cyc   = 0;

  // Reference model state
  bit          prev_ack;
  int          len_left;
  bit [LW-1:0] len_reg, shadow;
  longint      t0[2];
  longint      run_len[2];
  bit          ovf[2];
  bit          oa[2] = '{1'b1, 1'b0};
  int          seq_cnt[2];
  bit          rand_ff = 1'b0;

  always #5 clk = ~clk;

  acq_window_sequencer #(.LEN_WIDTH(LW), .OVERFLOW_ABORT(1'b1)) dut_abort (
    .clk(clk), .reset(reset), .mask_bit(mask_bit), .data(data), .data_ack(ack[0]),
    .fifo_full(fifo_full), .start_det(sd[0]), .stop_det(sp[0]), .reset_counter(rc[0]),
    .seq_operate(so[0]), .active(act[0]), .done(dn[0]), .overflow(ovf_o[0])
  );

  acq_window_sequencer #(.LEN_WIDTH(LW), .OVERFLOW_ABORT(1'b0)) dut_flag (
    .clk(clk), .reset(reset), .mask_bit(mask_bit), .data(data), .data_ack(ack[1]),
    .fifo_full(fifo_full), .start_det(sd[1]), .stop_det(sp[1]), .reset_counter(rc[1]),
    .seq_operate(so[1]), .active(act[1]), .done(dn[1]), .overflow(ovf_o[1])
  );

  task automatic chk(input string tag, input logic obs, input logic expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
    end
  endtask

  task automatic chk_int(input string tag, input longint obs, input longint expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Window schedule relative to the START-ack cycle t0: PREP t0+1, ARM t0+2,
  // RUN t0+3 .. t0+2+run_len, STOP next, DONE after. run_len<0 means aborted in PREP.
  function automatic void exp_out(input int i, output bit e_rc, output bit e_sd,
                                  output bit e_so, output bit e_sp, output bit e_act,
                                  output bit e_dn);
    longint rel, rl;
    e_rc = 0; e_sd = 0; e_so = 0; e_sp = 0; e_act = 0; e_dn = 0;
    if (t0[i] < 0) return;
    rel   = cyc - t0[i];
    rl    = run_len[i];
    e_rc  = (rel == 1);
    e_sd  = (rel == 2) && (rl >= 0);
    e_so  = (rel >= 3) && (rel <= 2 + rl);
    e_sp  = (rel == 3 + rl);
    e_dn  = (rel == 4 + rl);
    e_act = (rel >= 1) && (rel <= 3 + rl);
  endfunction

  task automatic model_update(input bit ack_e, input bit run_e[2]);
    bit st, ab, cl, busy, hit;
    longint rel, cut;
    st = 0; ab = 0; cl = 0;
    if (reset) begin
      prev_ack = 0; len_left = 0; len_reg = '0;
      for (int i = 0; i < 2; i++) begin
        t0[i] = -1; run_len[i] = 0; ovf[i] = 0;
      end
      return;
    end
    prev_ack = ack_e;
    if (ack_e) begin
      if (len_left > 0) begin
        shadow[8*(LW/8 - len_left) +: 8] = data;
        len_left--;
        if (len_left == 0) len_reg = shadow;
      end else begin
        case (data)
          8'h01:   len_left = LW/8;
          8'h02:   st = 1;
          8'h03:   ab = 1;
          8'h04:   cl = 1;
          default: ;
        endcase
      end
    end
    for (int i = 0; i < 2; i++) begin
      rel  = cyc - t0[i];
      busy = (t0[i] >= 0) && (rel >= 1) && (rel <= 4 + run_len[i]);
      hit  = run_e[i] && fifo_full;
      if (st && !busy && len_reg != 0) begin
        t0[i] = cyc;
        run_len[i] = longint'(len_reg);
      end else begin
        cut = -2;
        if (ab && busy) begin
          if (rel == 1) cut = -1;
          else if (rel == 2 && run_len[i] >= 0) cut = 0;
          else if (run_e[i]) cut = rel - 2;
        end
        if (oa[i] && hit) cut = rel - 2;
        if (cut != -2) run_len[i] = cut;
      end
      ovf[i] = hit ? 1'b1 : (cl ? 1'b0 : ovf[i]);
    end
  endtask

  task automatic cycle();
    bit e_rc, e_sd, e_so, e_sp, e_act, e_dn, ack_e;
    bit run_e[2];
    if (rand_ff) fifo_full = ($urandom_range(0, 19) == 0);
    @(negedge clk);
    ack_e = mask_bit && !prev_ack && !reset;
    for (int i = 0; i < 2; i++) begin
      exp_out(i, e_rc, e_sd, e_so, e_sp, e_act, e_dn);
      run_e[i] = e_so;
      chk("data_ack", ack[i], ack_e);
      chk("reset_counter", rc[i], e_rc);
      chk("start_det", sd[i], e_sd);
      chk("seq_operate", so[i], e_so);
      chk("stop_det", sp[i], e_sp);
      chk("active", act[i], e_act);
      chk("done", dn[i], e_dn);
      chk("overflow", ovf_o[i], ovf[i]);
      if (so[i] === 1'b1) seq_cnt[i]++;
    end
    model_update(ack_e, run_e);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    mask_bit = 0;
    repeat (n) cycle();
  endtask

  task automatic send(input logic [7:0] b, input bit hold = 1'b0);
    mask_bit = 1; data = b;
    for (int k = 0; k < 2 && prev_ack; k++) cycle();
    cycle();
    if (!hold) mask_bit = 0;
  endtask

  task automatic load_len(input logic [31:0] v);
    send(8'h01); send(v[7:0]); send(v[15:8]); send(v[23:16]); send(v[31:24]);
  endtask

  task automatic clr_cnt();
    seq_cnt[0] = 0; seq_cnt[1] = 0;
  endtask

  initial begin
    reset = 1; mask_bit = 0; data = 8'h00; fifo_full = 0;
    prev_ack = 0; len_left = 0; len_reg = '0; shadow = '0;
    for (int i = 0; i < 2; i++) begin t0[i] = -1; run_len[i] = 0; ovf[i] = 0; end
    clr_cnt();
    @(posedge clk); #1;
    repeat (2) cycle();
    reset = 0;
    idle(2);

    // Basic 5-cycle window
    load_len(32'd5); clr_cnt();
    send(8'h02); idle(12);
    chk_int("win5_seq_a", seq_cnt[0], 5);
    chk_int("win5_seq_f", seq_cnt[1], 5);

    // START with zero length, then START during RUN
    load_len(32'd0); clr_cnt();
    send(8'h02); idle(8);
    chk_int("len0_seq", seq_cnt[0], 0);
    load_len(32'd8); clr_cnt();
    send(8'h02); idle(2); send(8'h02); idle(16);
    chk_int("restart_seq", seq_cnt[0], 8);

    // ABORT in RUN cycle 10 of a 100-cycle window
    load_len(32'd100); clr_cnt();
    send(8'h02); idle(11); send(8'h03); idle(8);
    chk_int("abort_seq_a", seq_cnt[0], 10);
    chk_int("abort_seq_f", seq_cnt[1], 10);
    chk("abort_no_ovf", ovf_o[0], 1'b0);

    // fifo_full in RUN cycle 20 of a 50-cycle window
    load_len(32'd50); clr_cnt();
    send(8'h02); idle(21);
    fifo_full = 1; cycle(); fifo_full = 0;
    idle(40);
    chk_int("ovf_abort_seq", seq_cnt[0], 20);
    chk_int("ovf_flag_seq", seq_cnt[1], 50);
    chk("ovf_set_a", ovf_o[0], 1'b1);
    chk("ovf_set_f", ovf_o[1], 1'b1);
    send(8'h04); idle(2);
    chk("ovf_clr_a", ovf_o[0], 1'b0);
    chk("ovf_clr_f", ovf_o[1], 1'b0);

    // mask_bit held high across three bytes
    load_len(32'd3); idle(1); clr_cnt();
    mask_bit = 1;
    data = 8'h7F; cycle(); cycle();
    data = 8'h04; cycle(); cycle();
    data = 8'h02; cycle(); cycle();
    idle(10);
    chk_int("held_mask_seq", seq_cnt[0], 3);

    // Reset in RUN cycle 3, then a normal window
    load_len(32'd20);
    send(8'h02); idle(4);
    reset = 1; cycle(); reset = 0;
    chk("rst_seq_off", so[0], 1'b0);
    chk("rst_active_off", act[0], 1'b0);
    idle(4); clr_cnt();
    load_len(32'd4); send(8'h02); idle(10);
    chk_int("post_rst_seq", seq_cnt[0], 4);

    // Randomized command traffic
    rand_ff = 1;
    for (int n = 0; n < 400; n++) begin
      int r;
      bit h;
      r = $urandom_range(0, 99);
      h = $urandom_range(0, 1);
      if (r < 15) begin
        send(8'h01, h);
        send(8'($urandom_range(0, 30)), h);
        send(8'h00, h); send(8'h00, h); send(8'h00, h);
      end else if (r < 40) send(8'h02, h);
      else if (r < 52) send(8'h03, h);
      else if (r < 60) send(8'h04, h);
      else if (r < 68) send(8'($urandom_range(5, 255)), h);
      else if (r < 70) begin
        mask_bit = 0; reset = 1; cycle(); reset = 0;
      end else idle($urandom_range(0, 20));
    end
    rand_ff = 0; fifo_full = 0;
    idle(60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
